// File: rtl/fta_bus_pkg.sv
// Shared FTA memory-bus types: 128-bit single-beat command request and response.
package fta_bus_pkg;

  typedef logic [31:0] fta_address_t;
  typedef logic [5:0]  fta_cid_t;
  typedef logic [7:0]  fta_tid_t;

  typedef struct packed {
    fta_cid_t     cid;
    fta_tid_t     tid;
    logic         cyc;
    logic         we;
    logic [15:0]  sel;
    fta_address_t padr;
    logic [127:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_cid_t     cid;
    fta_tid_t     tid;
    logic         stall;
    logic         ack;
    logic         err;
    fta_address_t adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

endpackage

// File: rtl/video_pkg.sv
// Defaults and tag type for the video frame-buffer fetch reorder buffer.
package video_pkg;
  import fta_bus_pkg::*;

  localparam int       VIDEO_NTAG      = 16;
  localparam int       VIDEO_ADRSTEP   = 16;
  localparam fta_cid_t VIDEO_FETCH_CID = 6'd3;

  typedef logic [$clog2(VIDEO_NTAG)-1:0] video_rob_tag_t;

endpackage

// File: rtl/video_rob_ram.sv
// Reorder-buffer beat storage: one write port for accepted responses, one
// registered read port feeding the head-of-line output register.
module video_rob_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_adr] <= wr_dat;
  end

  // The read register doubles as the output data register, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_adr];
  end

endmodule

// File: rtl/video_fetch_rob.sv
// Frame-buffer fetch engine: issues tagged 128-bit reads for consecutive
// addresses and returns out-of-order responses to the display in address order.
module video_fetch_rob
  import fta_bus_pkg::*, video_pkg::*;
#(
  parameter int       NTAG    = VIDEO_NTAG,
  parameter fta_cid_t CID     = VIDEO_FETCH_CID,
  parameter int       ADRSTEP = VIDEO_ADRSTEP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 vSync,
  input  fta_address_t         base_adr,
  input  logic [19:0]          frame_beats,
  output fta_cmd_request128_t  req,
  input  fta_cmd_response128_t resp,
  output logic                 out_valid,
  output logic [127:0]         out_dat,
  input  logic                 out_ready,
  output logic [15:0]          drop_cnt
);

  localparam int TAGW = $clog2(NTAG);
  typedef logic [TAGW-1:0] tag_t;

  logic         vsync_q;
  logic         restart;
  fta_address_t adr;
  logic [19:0]  beats_left;
  tag_t         wr_ptr;
  tag_t         rd_ptr;
  logic [NTAG-1:0] inuse;
  logic [NTAG-1:0] valid;
  logic         epoch;

  logic issue;
  logic hit;
  logic acc_ok;
  logic acc_bad;
  logic drain;
  logic load;
  tag_t acc_tag;
  logic acc_ep;
  tag_t next_ptr;
  logic unused_resp;

  assign restart  = vSync & ~vsync_q;
  assign issue    = en && (beats_left != '0) && !inuse[wr_ptr] && !resp.stall && !restart;

  // The bit above the tag carries the frame epoch so stale responses are recognised.
  assign acc_tag  = resp.tid[TAGW-1:0];
  assign acc_ep   = resp.tid[TAGW];
  assign hit      = resp.ack && (resp.cid == CID) && !restart;
  assign acc_ok   = hit && (acc_ep == epoch) && inuse[acc_tag] && !valid[acc_tag];
  assign acc_bad  = hit && !acc_ok;

  assign drain    = out_valid && out_ready && !restart;
  assign next_ptr = drain ? rd_ptr + 1'b1 : rd_ptr;
  assign load     = !restart && (drain || !out_valid) && valid[next_ptr];

  assign unused_resp = ^{resp.adr, resp.err, resp.tid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      req        <= '0;
      adr        <= '0;
      beats_left <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inuse      <= '0;
      valid      <= '0;
      epoch      <= 1'b0;
      out_valid  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      vsync_q <= vSync;
      req.cyc <= issue;
      if (restart) begin
        adr        <= base_adr;
        beats_left <= frame_beats;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        inuse      <= '0;
        valid      <= '0;
        epoch      <= ~epoch;
        out_valid  <= 1'b0;
      end else begin
        if (issue) begin
          req.padr           <= adr;
          req.cid            <= CID;
          req.tid            <= fta_tid_t'({epoch, wr_ptr});
          req.we             <= 1'b0;
          req.sel            <= '1;
          inuse[wr_ptr]      <= 1'b1;
          wr_ptr             <= wr_ptr + 1'b1;
          adr                <= adr + fta_address_t'(ADRSTEP);
          beats_left         <= beats_left - 1'b1;
        end
        if (acc_ok) valid[acc_tag] <= 1'b1;
        if (acc_bad && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        if (drain) begin
          inuse[rd_ptr] <= 1'b0;
          valid[rd_ptr] <= 1'b0;
          rd_ptr        <= rd_ptr + 1'b1;
        end
        if (load)       out_valid <= 1'b1;
        else if (drain) out_valid <= 1'b0;
      end
    end
  end

  video_rob_ram #(
    .DEPTH(NTAG),
    .AW   (TAGW),
    .DW   (128)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (acc_ok),
    .wr_adr(acc_tag),
    .wr_dat(resp.dat),
    .rd_en (load),
    .rd_adr(next_ptr),
    .rd_dat(out_dat)
  );

endmodule

// File: tb/tb_video_fetch_rob.sv
// Directed bench for video_fetch_rob: ordering, reordering, tag exhaustion,
// restart epochs, discarded responses, back-pressure and asynchronous reset.
module tb_video_fetch_rob;
  import fta_bus_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic                 vSync;
  fta_address_t         base_adr;
  logic [19:0]          frame_beats;
  fta_cmd_request128_t  req;
  fta_cmd_response128_t resp;
  logic                 out_valid;
  logic [127:0]         out_dat;
  logic                 out_ready;
  logic [15:0]          drop_cnt;

  int total = 0;
  int passed = 0;
  int ncyc = 0;
  int first_valid = -1;
  bit auto_mem = 1'b0;

  typedef struct packed {
    logic [5:0]   cid;
    logic [7:0]   tid;
    logic [127:0] dat;
  } ack_t;

  ack_t         ack_q[$];
  ack_t         cur_ack;
  fta_address_t req_padr_q[$];
  logic [7:0]   req_tid_q[$];
  logic [127:0] out_q[$];
  int           out_cyc_q[$];
  int           ack_cyc[16];

  always #5 clk = ~clk;

  video_fetch_rob dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .vSync      (vSync),
    .base_adr   (base_adr),
    .frame_beats(frame_beats),
    .req        (req),
    .resp       (resp),
    .out_valid  (out_valid),
    .out_dat    (out_dat),
    .out_ready  (out_ready),
    .drop_cnt   (drop_cnt)
  );

  // Memory model: either echoes each request in the same cycle, or plays queued acks.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    #1;
    resp = '0;
    if (auto_mem && req.cyc) begin
      resp.ack = 1'b1;
      resp.cid = 6'd3;
      resp.tid = req.tid;
      resp.dat = {96'h0, req.padr};
      ack_cyc[req.tid[3:0]] = ncyc;
    end else if (ack_q.size() != 0) begin
      cur_ack  = ack_q.pop_front();
      resp.ack = 1'b1;
      resp.cid = cur_ack.cid;
      resp.tid = cur_ack.tid;
      resp.dat = cur_ack.dat;
      ack_cyc[cur_ack.tid[3:0]] = ncyc;
    end
  end

  always @(negedge clk) begin
    #3;
    if (req.cyc) begin
      req_padr_q.push_back(req.padr);
      req_tid_q.push_back(req.tid);
    end
    if (out_valid && first_valid < 0) first_valid = ncyc;
    if (out_valid && out_ready) begin
      out_q.push_back(out_dat);
      out_cyc_q.push_back(ncyc);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    req_padr_q.delete();
    req_tid_q.delete();
    out_q.delete();
    out_cyc_q.delete();
    first_valid = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    auto_mem = 1'b0;
    ack_q.delete();
    vSync = 1'b0;
    en = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic pulse_vsync(input fta_address_t b, input logic [19:0] n);
    @(negedge clk);
    base_adr = b;
    frame_beats = n;
    vSync = 1'b1;
    @(negedge clk);
    vSync = 1'b0;
  endtask

  task automatic push_ack(input logic [5:0] cid, input logic [7:0] tid, input logic [127:0] dat);
    ack_q.push_back('{cid: cid, tid: tid, dat: dat});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; vSync = 1'b0; out_ready = 1'b0;
    base_adr = '0; frame_beats = '0;
    #2;
    total++; if (req !== '0) $display("[TB] FAIL reset_req: got %h expected 0", req); else passed++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_dat !== '0) $display("[TB] FAIL reset_out_dat: got %h expected 0", out_dat); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_in_order();
    do_reset();
    out_ready = 1'b1;
    auto_mem = 1'b1;
    pulse_vsync(32'h1000, 20'd4);
    wait_cycles(15);
    total++; if (req_padr_q.size() !== 4) $display("[TB] FAIL in_order_req_count: got %0d expected 4", req_padr_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= req_padr_q.size() || req_padr_q[i] !== 32'h1000 + 32'(16 * i))
        $display("[TB] FAIL in_order_padr[%0d]: got %h expected %h", i, (i < req_padr_q.size()) ? req_padr_q[i] : 32'hx, 32'h1000 + 32'(16 * i));
      else passed++;
      total++;
      if (i >= req_tid_q.size() || req_tid_q[i] !== 8'h10 + 8'(i))
        $display("[TB] FAIL in_order_tid[%0d]: got %h expected %h", i, (i < req_tid_q.size()) ? req_tid_q[i] : 8'hx, 8'h10 + 8'(i));
      else passed++;
      total++;
      if (i >= out_q.size() || out_q[i] !== 128'h1000 + 128'(16 * i))
        $display("[TB] FAIL in_order_out[%0d]: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 128'hx, 128'h1000 + 128'(16 * i));
      else passed++;
    end
    auto_mem = 1'b0;
  endtask

  task automatic test_reorder();
    logic [7:0] order [4] = '{8'h12, 8'h10, 8'h13, 8'h11};
    do_reset();
    out_ready = 1'b1;
    pulse_vsync(32'h2000, 20'd4);
    wait_cycles(8);
    for (int i = 0; i < 4; i++) push_ack(6'd3, order[i], 128'(order[i][3:0]));
    wait_cycles(12);
    total++; if (out_q.size() !== 4) $display("[TB] FAIL reorder_count: got %0d expected 4", out_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= out_q.size() || out_q[i] !== 128'(i))
        $display("[TB] FAIL reorder_out[%0d]: got %h expected %0d", i, (i < out_q.size()) ? out_q[i] : 128'hx, i);
      else passed++;
    end
    total++; if (first_valid !== ack_cyc[0] + 2) $display("[TB] FAIL reorder_latency: got cycle %0d expected %0d", first_valid, ack_cyc[0] + 2); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("[TB] FAIL reorder_drop_cnt: got %0d expected 0", drop_cnt); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    out_ready = 1'b1;
    pulse_vsync(32'h4000, 20'd40);
    wait_cycles(25);
    total++; if (req_padr_q.size() !== 16) $display("[TB] FAIL full_req_count: got %0d expected 16", req_padr_q.size()); else passed++;
    total++; if (req_padr_q.size() == 0 || req_padr_q[req_padr_q.size()-1] !== 32'h40F0) $display("[TB] FAIL full_last_padr: got %0d reqs, expected last padr 40f0", req_padr_q.size()); else passed++;
    clear_logs();
    push_ack(6'd3, 8'h10, 128'hAA);
    wait_cycles(8);
    total++; if (out_q.size() !== 1) $display("[TB] FAIL full_drain_count: got %0d expected 1", out_q.size()); else passed++;
    total++; if (out_q.size() == 0 || out_q[0] !== 128'hAA) $display("[TB] FAIL full_drain_dat: got %0d beats, expected first aa", out_q.size()); else passed++;
    total++; if (req_padr_q.size() !== 1) $display("[TB] FAIL full_reissue_count: got %0d expected 1", req_padr_q.size()); else passed++;
    total++; if (req_tid_q.size() == 0 || req_tid_q[0] !== 8'h10) $display("[TB] FAIL full_reissue_tid: got %0d reqs, expected tid 10", req_tid_q.size()); else passed++;
    total++; if (req_padr_q.size() == 0 || req_padr_q[0] !== 32'h4100) $display("[TB] FAIL full_reissue_padr: got %h expected 4100", (req_padr_q.size() != 0) ? req_padr_q[0] : 32'hx); else passed++;
  endtask

  task automatic test_restart();
    do_reset();
    out_ready = 1'b1;
    pulse_vsync(32'h5000, 20'd5);
    wait_cycles(10);
    total++; if (req_tid_q.size() !== 5) $display("[TB] FAIL restart_old_count: got %0d expected 5", req_tid_q.size()); else passed++;
    total++; if (req_tid_q.size() == 0 || req_tid_q[0] !== 8'h10) $display("[TB] FAIL restart_old_tid: got %0d reqs, expected tid 10", req_tid_q.size()); else passed++;
    clear_logs();
    pulse_vsync(32'h8000, 20'd2);
    wait_cycles(5);
    for (int i = 0; i < 5; i++) push_ack(6'd3, 8'h10 + 8'(i), 128'hBEEF);
    wait_cycles(10);
    total++; if (drop_cnt !== 16'd5) $display("[TB] FAIL restart_drop_cnt: got %0d expected 5", drop_cnt); else passed++;
    total++; if (first_valid !== -1) $display("[TB] FAIL restart_no_out: got out_valid at cycle %0d expected never", first_valid); else passed++;
    total++; if (req_padr_q.size() !== 2) $display("[TB] FAIL restart_new_count: got %0d expected 2", req_padr_q.size()); else passed++;
    total++; if (req_padr_q.size() < 2 || req_padr_q[0] !== 32'h8000 || req_padr_q[1] !== 32'h8010) $display("[TB] FAIL restart_new_padr: got %0d reqs, expected 8000,8010", req_padr_q.size()); else passed++;
    total++; if (req_tid_q.size() < 2 || req_tid_q[0] !== 8'h00 || req_tid_q[1] !== 8'h01) $display("[TB] FAIL restart_new_tid: got %0d reqs, expected 00,01", req_tid_q.size()); else passed++;
  endtask

  task automatic test_drops();
    do_reset();
    pulse_vsync(32'h3000, 20'd4);
    wait_cycles(8);
    push_ack(6'd3, 8'h11, 128'h1111);
    wait_cycles(4);
    total++; if (drop_cnt !== 16'd0) $display("[TB] FAIL drops_first_ack: got %0d expected 0", drop_cnt); else passed++;
    push_ack(6'd3, 8'h11, 128'hDEAD);
    wait_cycles(4);
    total++; if (drop_cnt !== 16'd1) $display("[TB] FAIL drops_duplicate: got %0d expected 1", drop_cnt); else passed++;
    push_ack(6'd5, 8'h12, 128'h2222);
    wait_cycles(4);
    total++; if (drop_cnt !== 16'd1) $display("[TB] FAIL drops_cid_mismatch: got %0d expected 1", drop_cnt); else passed++;
    push_ack(6'd3, 8'h15, 128'h5555);
    wait_cycles(4);
    total++; if (drop_cnt !== 16'd2) $display("[TB] FAIL drops_unissued: got %0d expected 2", drop_cnt); else passed++;
    push_ack(6'd3, 8'h10, 128'h1000);
    wait_cycles(4);
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL drops_head_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_dat !== 128'h1000) $display("[TB] FAIL drops_head_dat: got %h expected 1000", out_dat); else passed++;
    @(negedge clk);
    out_ready = 1'b1;
    wait_cycles(6);
    total++; if (out_q.size() !== 2) $display("[TB] FAIL drops_beat_count: got %0d expected 2", out_q.size()); else passed++;
    total++; if (out_q.size() < 2 || out_q[1] !== 128'h1111) $display("[TB] FAIL drops_tid1_dat: got %0d beats, expected second 1111", out_q.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    auto_mem = 1'b1;
    pulse_vsync(32'h6000, 20'd40);
    wait_cycles(22);
    total++; if (req_padr_q.size() !== 16) $display("[TB] FAIL b2b_outstanding: got %0d expected 16", req_padr_q.size()); else passed++;
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL b2b_head_valid: got %b expected 1", out_valid); else passed++;
    total++; if (out_dat !== 128'h6000) $display("[TB] FAIL b2b_head_dat: got %h expected 6000", out_dat); else passed++;
    @(negedge clk);
    out_ready = 1'b1;
    wait_cycles(20);
    total++; if (out_q.size() < 16) $display("[TB] FAIL b2b_beat_count: got %0d expected at least 16", out_q.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (i >= out_q.size() || out_q[i] !== 128'h6000 + 128'(16 * i) || out_cyc_q[i] !== out_cyc_q[0] + i)
        $display("[TB] FAIL b2b_beat[%0d]: got %h at cycle offset %0d expected %h at offset %0d", i,
                 (i < out_q.size()) ? out_q[i] : 128'hx, (i < out_q.size()) ? out_cyc_q[i] - out_cyc_q[0] : -1,
                 128'h6000 + 128'(16 * i), i);
      else passed++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (req !== '0) $display("[TB] FAIL async_reset_req: got %h expected 0", req); else passed++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL async_reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_dat !== '0) $display("[TB] FAIL async_reset_out_dat: got %h expected 0", out_dat); else passed++;
    total++; if (drop_cnt !== 16'd0) $display("[TB] FAIL async_reset_drop_cnt: got %0d expected 0", drop_cnt); else passed++;
    auto_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] starting video_fetch_rob bench");
    test_reset();
    test_in_order();
    test_reorder();
    test_full();
    test_restart();
    test_drops();
    test_back_to_back();
    wait_cycles(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
